// File: rtl/srec_emitter_if.sv
// Byte-stream bus of srec_emitter: the memory read port on one side and the
// character stream to the UART transmitter on the other.
//   mem_read_enable   master -> slave  one-cycle read request
//   mem_read_address  master -> slave  byte address of the request
//   mem_read_byte     slave  -> master read data, valid one cycle after the request
//   char_data         master -> slave  ASCII character
//   char_valid        master -> slave  char_data is valid
//   char_ready        slave  -> master transmitter accepts char_data this cycle
interface srec_emitter_if;
  logic        mem_read_enable;
  logic [31:0] mem_read_address;
  logic [7:0]  mem_read_byte;
  logic [7:0]  char_data;
  logic        char_valid;
  logic        char_ready;

  modport master (
    output mem_read_enable,
    output mem_read_address,
    input  mem_read_byte,
    output char_data,
    output char_valid,
    input  char_ready
  );

  modport slave (
    input  mem_read_enable,
    input  mem_read_address,
    output mem_read_byte,
    input  char_data,
    input  char_valid,
    output char_ready
  );
endinterface

// File: rtl/srec_emitter.sv
// Motorola S-record emitter. Dumps a byte-addressed memory region as S3 data
// records ("S3", count, 8-digit address, data, checksum, CR LF), one ASCII
// character per handshake, uppercase hex.
// Optional feature macro SREC_EMITTER_S7_EN: when defined, the dump ends with the
// terminator line "S70500000000FA" CR LF; otherwise it ends after the last S3 line.
// Ports:
//   clock, reset_n      clock and synchronous active-low reset
//   start               one-cycle pulse, accepted only while idle
//   start_address       first byte address, captured on accepted start
//   length              number of bytes to dump, captured on accepted start
//   busy                high from the cycle after an accepted start until done
//   done                one-cycle pulse after the final LF transfer
//   bus                 memory read port and character stream (srec_emitter_if.master)
module srec_emitter #(
  parameter int unsigned BYTES_PER_RECORD = 16,
  parameter int unsigned LENGTH_W         = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic [31:0]         start_address,
  input  logic [LENGTH_W-1:0] length,
  output logic                busy,
  output logic                done,
  srec_emitter_if.master      bus
);

  typedef enum logic [3:0] {
    StIdle, StRecS, StRecType, StCntHi, StCntLo, StAddr, StRdReq, StRdWait,
    StDataHi, StDataLo, StSumHi, StSumLo, StEolCr, StEolLf, StTerm
  } state_e;

  state_e              state_q;
  logic                busy_q, done_q;
  logic                char_valid_q;
  logic [7:0]          char_data_q;
  logic                mem_re_q;
  logic [31:0]         mem_addr_q;
  logic [31:0]         rec_addr_q;    // address field of the current record
  logic [31:0]         rd_ptr_q;      // next byte to read
  logic [LENGTH_W-1:0] remaining_q;   // bytes not yet assigned to a record
  logic [7:0]          rec_left_q;    // bytes still to emit in this record
  logic [7:0]          count_q;
  logic [7:0]          sum_q;         // running (uninverted) checksum
  logic [7:0]          byte_q;
  logic [2:0]          nib_idx_q;
`ifdef SREC_EMITTER_S7_EN
  logic [3:0]          term_idx_q;
`endif

  function automatic logic [7:0] hex(input logic [3:0] v);
    return (v < 4'd10) ? (8'h30 + {4'h0, v}) : (8'h37 + {4'h0, v});
  endfunction

`ifdef SREC_EMITTER_S7_EN
  function automatic logic [7:0] term_char(input logic [3:0] i);
    case (i)
      4'd0:    return "S";
      4'd1:    return "7";
      4'd3:    return "5";
      4'd12:   return "F";
      4'd13:   return "A";
      4'd14:   return 8'h0d;
      4'd15:   return 8'h0a;
      default: return "0";
    endcase
  endfunction
`endif

  // Parameters of the record about to start: taken from the start inputs when
  // idle, from the running pointers when chaining records.
  logic                xfer;
  logic [LENGTH_W-1:0] rec_rem;
  logic [31:0]         rec_addr;
  logic [7:0]          rec_n, rec_cnt, rec_sum0;
  logic                load_rec;

  assign xfer = char_valid_q & bus.char_ready;

  always_comb begin
    rec_rem  = (state_q == StIdle) ? length : remaining_q;
    rec_addr = (state_q == StIdle) ? start_address : rd_ptr_q;
    if (32'(rec_rem) >= BYTES_PER_RECORD) rec_n = 8'(BYTES_PER_RECORD);
    else                                  rec_n = 8'(rec_rem);
    rec_cnt  = rec_n + 8'd5;
    rec_sum0 = rec_cnt + rec_addr[31:24] + rec_addr[23:16] + rec_addr[15:8] + rec_addr[7:0];
    load_rec = ((state_q == StIdle) && start && (length != '0)) ||
               ((state_q == StEolLf) && xfer && (remaining_q != '0));
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      char_valid_q <= 1'b0;
      char_data_q  <= 8'h00;
      mem_re_q     <= 1'b0;
      mem_addr_q   <= 32'h0;
      rec_addr_q   <= 32'h0;
      rd_ptr_q     <= 32'h0;
      remaining_q  <= '0;
      rec_left_q   <= 8'h0;
      count_q      <= 8'h0;
      sum_q        <= 8'h0;
      byte_q       <= 8'h0;
      nib_idx_q    <= 3'd0;
`ifdef SREC_EMITTER_S7_EN
      term_idx_q   <= 4'd0;
`endif
    end else begin
      done_q   <= 1'b0;
      mem_re_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            if (length != '0) begin
              state_q      <= StRecS;
              busy_q       <= 1'b1;
              char_valid_q <= 1'b1;
              char_data_q  <= "S";
            end else begin
`ifdef SREC_EMITTER_S7_EN
              state_q      <= StTerm;
              term_idx_q   <= 4'd0;
              busy_q       <= 1'b1;
              char_valid_q <= 1'b1;
              char_data_q  <= "S";
`else
              done_q       <= 1'b1;
`endif
            end
          end
        end
        StRecS: if (xfer) begin
          state_q     <= StRecType;
          char_data_q <= "3";
        end
        StRecType: if (xfer) begin
          state_q     <= StCntHi;
          char_data_q <= hex(count_q[7:4]);
        end
        StCntHi: if (xfer) begin
          state_q     <= StCntLo;
          char_data_q <= hex(count_q[3:0]);
        end
        StCntLo: if (xfer) begin
          state_q     <= StAddr;
          nib_idx_q   <= 3'd0;
          char_data_q <= hex(rec_addr_q[31:28]);
        end
        StAddr: if (xfer) begin
          if (nib_idx_q != 3'd7) begin
            nib_idx_q   <= nib_idx_q + 3'd1;
            char_data_q <= hex(rec_addr_q[{3'd6 - nib_idx_q, 2'b00} +: 4]);
          end else begin
            state_q      <= StRdReq;
            char_valid_q <= 1'b0;
            mem_re_q     <= 1'b1;
            mem_addr_q   <= rd_ptr_q;
            rd_ptr_q     <= rd_ptr_q + 32'd1;
          end
        end
        StRdReq: state_q <= StRdWait;
        StRdWait: begin
          // Read data is valid in this cycle only.
          byte_q       <= bus.mem_read_byte;
          sum_q        <= sum_q + bus.mem_read_byte;
          state_q      <= StDataHi;
          char_valid_q <= 1'b1;
          char_data_q  <= hex(bus.mem_read_byte[7:4]);
        end
        StDataHi: if (xfer) begin
          state_q     <= StDataLo;
          char_data_q <= hex(byte_q[3:0]);
        end
        StDataLo: if (xfer) begin
          rec_left_q <= rec_left_q - 8'd1;
          if (rec_left_q != 8'd1) begin
            state_q      <= StRdReq;
            char_valid_q <= 1'b0;
            mem_re_q     <= 1'b1;
            mem_addr_q   <= rd_ptr_q;
            rd_ptr_q     <= rd_ptr_q + 32'd1;
          end else begin
            state_q     <= StSumHi;
            char_data_q <= hex(~sum_q[7:4]);
          end
        end
        StSumHi: if (xfer) begin
          state_q     <= StSumLo;
          char_data_q <= hex(~sum_q[3:0]);
        end
        StSumLo: if (xfer) begin
          state_q     <= StEolCr;
          char_data_q <= 8'h0d;
        end
        StEolCr: if (xfer) begin
          state_q     <= StEolLf;
          char_data_q <= 8'h0a;
        end
        StEolLf: if (xfer) begin
          if (remaining_q != '0) begin
            state_q     <= StRecS;
            char_data_q <= "S";
          end else begin
`ifdef SREC_EMITTER_S7_EN
            state_q      <= StTerm;
            term_idx_q   <= 4'd0;
            char_data_q  <= "S";
`else
            state_q      <= StIdle;
            char_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
`endif
          end
        end
`ifdef SREC_EMITTER_S7_EN
        StTerm: if (xfer) begin
          if (term_idx_q != 4'd15) begin
            term_idx_q  <= term_idx_q + 4'd1;
            char_data_q <= term_char(term_idx_q + 4'd1);
          end else begin
            state_q      <= StIdle;
            char_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
          end
        end
`endif
        default: begin
          state_q      <= StIdle;
          char_valid_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase

      if (load_rec) begin
        rec_addr_q  <= rec_addr;
        rd_ptr_q    <= rec_addr;
        remaining_q <= rec_rem - LENGTH_W'(rec_n);
        rec_left_q  <= rec_n;
        count_q     <= rec_cnt;
        sum_q       <= rec_sum0;
      end
    end
  end

  assign busy                 = busy_q;
  assign done                 = done_q;
  assign bus.char_valid       = char_valid_q;
  assign bus.char_data        = char_data_q;
  assign bus.mem_read_enable  = mem_re_q;
  assign bus.mem_read_address = mem_addr_q;

endmodule
